// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first. Pins are oversampled in the clk domain; the CPU side
// sees a one-byte TX holding register and a one-byte RX buffer with an overrun flag.
module spi_slave #(
  parameter logic [7:0] FILL_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ssn,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, ssn_sr;
  logic                   sclk_q, ssn_q;
  logic                   sclk_s, mosi_s, ssn_s;
  logic                   sclk_rise, sclk_fall, ssn_fall, ssn_rise;
  logic                   in_shift, byte_done, bound_fall, reload;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_in, shift_out, tx_buf;
  logic [7:0]             reload_val, shift_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sr <= '0;
      mosi_sr <= '0;
      ssn_sr  <= '1;
      sclk_q  <= 1'b0;
      ssn_q   <= 1'b1;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      ssn_sr  <= {ssn_sr[SYNC_STAGES-2:0], ssn};
      sclk_q  <= sclk_s;
      ssn_q   <= ssn_s;
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign ssn_s     = ssn_sr[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s &  sclk_q;
  assign ssn_fall  = ~ssn_s  &  ssn_q;
  assign ssn_rise  =  ssn_s  & ~ssn_q;

  // Deselect wins over any sclk edge seen in the same cycle.
  assign in_shift   = (state == SHIFT) && !ssn_rise;
  assign byte_done  = in_shift && sclk_rise && (bit_cnt == 3'd7);
  assign bound_fall = in_shift && sclk_fall && (bit_cnt == 3'd0);
  assign reload     = ((state == IDLE) && ssn_fall) || bound_fall;
  assign reload_val = tx_ready ? FILL_BYTE : tx_buf;
  assign shift_nxt  = (bit_cnt == 3'd0) ? reload_val : {shift_out[6:0], 1'b0};
  assign busy       = (state == SHIFT) && (bit_cnt != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift_in  <= 8'h00;
      shift_out <= FILL_BYTE;
      tx_buf    <= 8'h00;
      tx_ready  <= 1'b1;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      // A load in the same cycle as a reload stays pending: the reload used the old byte.
      if (tx_load) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end else if (reload) begin
        tx_ready <= 1'b1;
      end

      if (rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      if (byte_done) begin
        rx_data  <= {shift_in[6:0], mosi_s};
        rx_valid <= 1'b1;
        if (rx_valid && !rx_ack) overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          if (ssn_fall) begin
            state     <= SHIFT;
            bit_cnt   <= 3'd0;
            shift_out <= reload_val;
            miso      <= reload_val[7];
            miso_oe   <= 1'b1;
          end
        end
        SHIFT: begin
          if (ssn_rise) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
          end else begin
            if (sclk_rise) begin
              shift_in <= {shift_in[6:0], mosi_s};
              bit_cnt  <= bit_cnt + 3'd1;
            end
            // miso moves with shift_out so the next MSB is on the pin well before the rise.
            if (sclk_fall) begin
              shift_out <= shift_nxt;
              miso      <= shift_nxt[7];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged mode-0 master on negedge clk plus a byte-level model
// of the TX holding register and RX buffer.
module tb_spi_slave;
  localparam logic [7:0] FILL = 8'hFF;
  localparam int         SYNC = 2;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sclk = 1'b0, mosi = 1'b0, ssn = 1'b1;
  logic       miso, miso_oe, tx_ready, rx_valid, overrun, busy;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic       tx_load = 1'b0, rx_ack = 1'b0;

  int n_tests = 0, n_fail = 0;

  // byte-level model
  logic       m_pend = 1'b0, m_rxv = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_txb = 8'h00, m_cur = FILL, m_rxd = 8'h00;

  spi_slave #(.FILL_BYTE(FILL), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ssn(ssn),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tx_put(input logic [7:0] v);
    @(negedge clk); tx_data = v; tx_load = 1'b1;
    @(negedge clk); tx_load = 1'b0;
    m_pend = 1'b1; m_txb = v;
  endtask

  task automatic ack_pulse();
    @(negedge clk); rx_ack = 1'b1;
    @(negedge clk); rx_ack = 1'b0;
    m_rxv = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic frame_start();
    ssn = 1'b0;
    m_cur = m_pend ? m_txb : FILL; m_pend = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    ssn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // sclk = clk/8; optional tx_load at the start, optional rx_ack landing on the byte-complete cycle.
  task automatic spi_byte(input logic [7:0] mo, input int nbits, input bit do_load,
                          input logic [7:0] ld, input bit ack_done,
                          output logic [7:0] mi, output int lat);
    mi = 8'h00; lat = -1;
    if (do_load) begin tx_data = ld; tx_load = 1'b1; end
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      @(negedge clk); tx_load = 1'b0;
      repeat (3) @(negedge clk);
      sclk = 1'b1; mi[7-i] = miso;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (i == 7 && lat < 0 && rx_valid) lat = k;
        if (i == 7 && ack_done) rx_ack = (k == 2);
      end
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    tx_load = 1'b0;
    if (do_load) begin m_pend = 1'b1; m_txb = ld; end
    if (nbits == 8) begin
      if (ack_done) m_ovr = 1'b0; else if (m_rxv) m_ovr = 1'b1;
      m_rxv = 1'b1; m_rxd = mo;
      m_cur = m_pend ? m_txb : FILL; m_pend = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (miso_oe !== 1'b0 || miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got oe=%b miso=%b exp 0 0", miso_oe, miso); end
    n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
    n_tests++; if ({rx_valid, overrun, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {rx_valid, overrun, busy}); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [7:0] mi; int lat;
    tx_put(8'hA5);
    frame_start();
    n_tests++; if (miso_oe !== 1'b1) begin n_fail++; $display("FAIL single_oe got %b exp 1", miso_oe); end
    spi_byte(8'h3C, 8, 1'b0, 8'h00, 1'b0, mi, lat);
    n_tests++; if (mi !== 8'hA5) begin n_fail++; $display("FAIL single_miso got %h exp a5", mi); end
    n_tests++; if (rx_data !== 8'h3C || rx_valid !== 1'b1) begin n_fail++; $display("FAIL single_rx got %h/%b exp 3c/1", rx_data, rx_valid); end
    n_tests++; if (lat !== SYNC + 1) begin n_fail++; $display("FAIL single_latency got %0d exp %0d", lat, SYNC + 1); end
    n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL single_tx_ready got %b exp 1", tx_ready); end
    frame_end();
    n_tests++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL single_oe_off got %b exp 0", miso_oe); end
    ack_pulse();
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi; int lat;
    tx_put(8'h11);
    frame_start();
    n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_tx_ready got %b exp 1", tx_ready); end
    spi_byte(8'hF0, 8, 1'b1, 8'h22, 1'b0, mi, lat);
    n_tests++; if (mi !== 8'h11 || rx_data !== 8'hF0) begin n_fail++; $display("FAIL b2b_byte0 got miso %h rx %h exp 11 f0", mi, rx_data); end
    ack_pulse();
    spi_byte(8'h0F, 8, 1'b0, 8'h00, 1'b0, mi, lat);
    n_tests++; if (mi !== 8'h22 || rx_data !== 8'h0F) begin n_fail++; $display("FAIL b2b_byte1 got miso %h rx %h exp 22 0f", mi, rx_data); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
    ack_pulse();
    frame_end();
  endtask

  task automatic test_underrun();
    logic [7:0] mi; int lat;
    for (int i = 0; i < 6; i++) begin
      repeat (4) @(negedge clk); sclk = ~sclk;
    end
    repeat (4) @(negedge clk);
    n_tests++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL idle_sclk got busy %b rxv %b exp 0 0", busy, rx_valid); end
    frame_start();
    spi_byte(8'h55, 8, 1'b0, 8'h00, 1'b0, mi, lat);
    n_tests++; if (mi !== 8'hFF || rx_data !== 8'h55) begin n_fail++; $display("FAIL underrun got miso %h rx %h exp ff 55", mi, rx_data); end
    ack_pulse();
    frame_end();
  endtask

  task automatic test_overrun();
    logic [7:0] mi; int lat;
    frame_start();
    spi_byte(8'h01, 8, 1'b0, 8'h00, 1'b0, mi, lat);
    spi_byte(8'h02, 8, 1'b0, 8'h00, 1'b0, mi, lat);
    n_tests++; if (rx_data !== 8'h02 || overrun !== 1'b1 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_set got %h ovr %b rxv %b exp 02 1 1", rx_data, overrun, rx_valid); end
    ack_pulse();
    n_tests++; if (rx_valid !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got rxv %b ovr %b exp 0 0", rx_valid, overrun); end
    // ack landing on the completing cycle: no overrun, new byte kept
    spi_byte(8'h33, 8, 1'b0, 8'h00, 1'b0, mi, lat);
    spi_byte(8'h44, 8, 1'b0, 8'h00, 1'b1, mi, lat);
    n_tests++; if (rx_data !== 8'h44 || rx_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL ack_collide got %h rxv %b ovr %b exp 44 1 0", rx_data, rx_valid, overrun); end
    ack_pulse();
    frame_end();
  endtask

  task automatic test_abort();
    logic [7:0] mi; int lat;
    frame_start();
    spi_byte(8'hE7, 5, 1'b1, 8'h5C, 1'b0, mi, lat);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy got %b exp 1", busy); end
    frame_end();
    n_tests++; if (rx_valid !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b0) begin n_fail++; $display("FAIL abort_state got rxv %b busy %b txr %b exp 0 0 0", rx_valid, busy, tx_ready); end
    frame_start();
    spi_byte(8'h9A, 8, 1'b0, 8'h00, 1'b0, mi, lat);
    n_tests++; if (mi !== 8'h5C || rx_data !== 8'h9A) begin n_fail++; $display("FAIL abort_next got miso %h rx %h exp 5c 9a", mi, rx_data); end
    ack_pulse();
    frame_end();
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi; int lat;
    frame_start();
    spi_byte(8'hA7, 8, 1'b1, 8'h3E, 1'b0, mi, lat);
    spi_byte(8'hC0, 3, 1'b0, 8'h00, 1'b0, mi, lat);
    n_tests++; if (busy !== 1'b1 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset got busy %b rxv %b exp 1 1", busy, rx_valid); end
    rst_n = 1'b0; #1;
    n_tests++; if ({miso, miso_oe, rx_valid, overrun, busy} !== 5'b0 || tx_ready !== 1'b1 || rx_data !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset got miso %b oe %b rxv %b ovr %b busy %b txr %b rx %h exp all reset", miso, miso_oe, rx_valid, overrun, busy, tx_ready, rx_data);
    end
    ssn = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_pend = 1'b0; m_rxv = 1'b0; m_ovr = 1'b0; m_rxd = 8'h00; m_cur = FILL;
    repeat (4) @(negedge clk);
    tx_put(8'hC3);
    frame_start();
    spi_byte(8'h81, 8, 1'b0, 8'h00, 1'b0, mi, lat);
    n_tests++; if (mi !== 8'hC3 || rx_data !== 8'h81 || overrun !== 1'b0) begin n_fail++; $display("FAIL post_reset got miso %h rx %h ovr %b exp c3 81 0", mi, rx_data, overrun); end
    ack_pulse();
    frame_end();
  endtask

  task automatic test_random();
    logic [7:0] mi, exp_mi, mo, ld; int lat, nb;
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 1) == 1) tx_put(8'($urandom));
      frame_start();
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        mo = 8'($urandom); ld = 8'($urandom); exp_mi = m_cur;
        spi_byte(mo, 8, $urandom_range(0, 1) == 1, ld, $urandom_range(0, 3) == 0, mi, lat);
        n_tests++; if (mi !== exp_mi) begin n_fail++; $display("FAIL rand_miso f%0d b%0d got %h exp %h", f, b, mi, exp_mi); end
        n_tests++; if (rx_data !== m_rxd || rx_valid !== m_rxv || overrun !== m_ovr || tx_ready !== ~m_pend) begin
          n_fail++; $display("FAIL rand_state f%0d b%0d got rx %h v%b o%b t%b exp rx %h v%b o%b t%b", f, b, rx_data, rx_valid, overrun, tx_ready, m_rxd, m_rxv, m_ovr, ~m_pend);
        end
        if ($urandom_range(0, 1) == 1) ack_pulse();
      end
      frame_end();
    end
    ack_pulse();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
